// File: rtl/bnn_accum_act.sv
// BNN accumulate-and-activate CFU: sums popcount-derived +/-1 dot products into a saturating
// signed accumulator, thresholds it into a 32-bit activation shift register, one-cycle response.
module bnn_accum_act #(
    parameter int unsigned CFU_FUNCTION_ID_W = 2,
    parameter int unsigned CFU_REQ_INPUTS    = 2,
    parameter int unsigned CFU_REQ_DATA_W    = 32,
    parameter int unsigned CFU_RESP_DATA_W   = 32,
    parameter int unsigned ACC_W             = 16
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [CFU_FUNCTION_ID_W-1:0]              req_function_id,
    // Operand k occupies bits [k*CFU_REQ_DATA_W +: CFU_REQ_DATA_W].
    input  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]  req_data,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [CFU_RESP_DATA_W-1:0]                resp_data
);

    localparam int unsigned SumW = ACC_W + 8;

    localparam logic [CFU_FUNCTION_ID_W-1:0] FnClear  = CFU_FUNCTION_ID_W'(0);
    localparam logic [CFU_FUNCTION_ID_W-1:0] FnAccum  = CFU_FUNCTION_ID_W'(1);
    localparam logic [CFU_FUNCTION_ID_W-1:0] FnThresh = CFU_FUNCTION_ID_W'(2);
    localparam logic [CFU_FUNCTION_ID_W-1:0] FnRead   = CFU_FUNCTION_ID_W'(3);

    localparam logic signed [SumW-1:0] AccMax = {{9{1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SumW-1:0] AccMin = {{9{1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                       state_q, state_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [31:0]                  act_q, act_d;
    logic [5:0]                   nbits_q, nbits_d;
    logic [CFU_RESP_DATA_W-1:0]   resp_data_q, resp_data_d;

    logic [CFU_REQ_DATA_W-1:0]    op0, op1;
    logic [5:0]                   pc_raw, n_raw, pc, n;
    logic signed [SumW-1:0]       delta, sum;
    logic signed [ACC_W-1:0]      acc_sat, thr;
    logic                         thr_bit;
    logic [31:0]                  act_shift;
    logic [5:0]                   nbits_inc;
    logic                         accept;
    logic                         unused_bits;

    assign op0 = req_data[CFU_REQ_DATA_W-1:0];
    assign op1 = req_data[2*CFU_REQ_DATA_W-1:CFU_REQ_DATA_W];
    assign unused_bits = ^req_data;

    assign resp_valid = (state_q == StFull);
    assign req_ready  = !resp_valid || resp_ready;
    assign accept     = req_valid && req_ready;
    assign resp_data  = resp_data_q;

    // Popcount pc of n bits maps to a +/-1 dot product of 2*pc - n.
    always_comb begin
        pc_raw = op0[5:0];
        n_raw  = op1[5:0];
        n      = (n_raw == 6'd0) ? 6'd32 : n_raw;
        pc     = (pc_raw > n) ? n : pc_raw;
        delta  = SumW'({pc, 1'b0}) - SumW'(n);
        sum    = SumW'(acc_q) + delta;
        if (sum > AccMax) begin
            acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (sum < AccMin) begin
            acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_sat = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        thr       = op0[ACC_W-1:0];
        thr_bit   = (acc_q >= thr) ? 1'b0 : 1'b1;
        act_shift = {act_q[30:0], thr_bit};
        nbits_inc = (nbits_q == 6'd32) ? 6'd32 : nbits_q + 6'd1;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        act_d       = act_q;
        nbits_d     = nbits_q;
        resp_data_d = resp_data_q;

        if (accept) begin
            state_d = StFull;
            case (req_function_id)
                FnClear: begin
                    acc_d       = '0;
                    act_d       = '0;
                    nbits_d     = '0;
                    resp_data_d = '0;
                end
                FnAccum: begin
                    acc_d       = acc_sat;
                    resp_data_d = CFU_RESP_DATA_W'(acc_sat);
                end
                FnThresh: begin
                    acc_d       = '0;
                    act_d       = act_shift;
                    nbits_d     = nbits_inc;
                    resp_data_d = CFU_RESP_DATA_W'(act_shift);
                end
                FnRead: begin
                    resp_data_d = op0[1] ? CFU_RESP_DATA_W'({26'b0, nbits_q})
                                         : CFU_RESP_DATA_W'(act_q);
                    if (op0[0]) begin
                        act_d   = '0;
                        nbits_d = '0;
                    end
                end
                default: resp_data_d = '0;
            endcase
        end else if (resp_valid && resp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StEmpty;
            acc_q       <= '0;
            act_q       <= '0;
            nbits_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            act_q       <= act_d;
            nbits_q     <= nbits_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_bnn_accum_act.sv
// Directed self-checking bench for bnn_accum_act, built with an 8-bit accumulator so
// saturation is reachable in a few requests.
module tb_bnn_accum_act;

    localparam logic [1:0] FnClear  = 2'd0;
    localparam logic [1:0] FnAccum  = 2'd1;
    localparam logic [1:0] FnThresh = 2'd2;
    localparam logic [1:0] FnRead   = 2'd3;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_function_id;
    logic [63:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    int n_checks;
    int n_fail;

    bnn_accum_act #(
        .CFU_FUNCTION_ID_W (2),
        .CFU_REQ_INPUTS    (2),
        .CFU_REQ_DATA_W    (32),
        .CFU_RESP_DATA_W   (32),
        .ACC_W             (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_function_id (req_function_id),
        .req_data        (req_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request with resp_ready=1; returns #1 after the accepting edge, when the
    // registered response is visible.
    task automatic send(input logic [1:0] f, input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clock);
        resp_ready      = 1'b1;
        req_valid       = 1'b1;
        req_function_id = f;
        req_data        = {d1, d0};
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset_n         = 1'b0;
        req_valid       = 1'b0;
        req_function_id = 2'd0;
        req_data        = '0;
        resp_ready      = 1'b1;

        #12;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_data", resp_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 2*20-32 = +8, then 2*12-32 = -8 -> 0
        send(FnAccum, 32'd20, 32'd32);
        check("accum1_valid", {31'b0, resp_valid}, 32'd1);
        check("accum1", resp_data, 32'd8);
        send(FnAccum, 32'd12, 32'd32);
        check("accum2", resp_data, 32'd0);
        // n field 0 means 32; pc=40 clamps to 32 -> +32
        send(FnAccum, 32'd40, 32'd0);
        check("accum_clamp", resp_data, 32'h20);
        // upper operand bits ignored: pc=3, n=5 -> +1
        send(FnAccum, 32'hFFFF_FFC3, 32'hABCD_0005);
        check("accum_ignore_hi", resp_data, 32'h21);
        send(FnClear, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("clear", resp_data, 32'd0);

        // acc=5; thr=5 -> bit 0; acc=0 vs thr=1 -> bit 1; acc=0 vs thr=-1 -> bit 0
        send(FnAccum, 32'd5, 32'd5);
        check("accum_5", resp_data, 32'd5);
        send(FnThresh, 32'd5, 32'd0);
        check("thresh_eq", resp_data, 32'h0);
        send(FnThresh, 32'd1, 32'd0);
        check("thresh_lt", resp_data, 32'h1);
        send(FnAccum, 32'd16, 32'd32);
        check("acc_zero_after_thr", resp_data, 32'd0);
        send(FnThresh, 32'h0000_00FF, 32'd0);
        check("thresh_neg_thr", resp_data, 32'h2);
        send(FnRead, 32'd2, 32'd0);
        check("read_nbits3", resp_data, 32'd3);
        send(FnRead, 32'd0, 32'd0);
        check("read_act_keep", resp_data, 32'h2);
        send(FnRead, 32'd1, 32'd0);
        check("read_act_clr", resp_data, 32'h2);
        send(FnRead, 32'd2, 32'd0);
        check("read_nbits_clr", resp_data, 32'd0);

        // Saturation with ACC_W=8
        send(FnClear, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) send(FnAccum, 32'd32, 32'd32);
        check("sat_pos", resp_data, 32'h0000_007F);
        send(FnAccum, 32'd0, 32'd32);
        check("sat_pos_down", resp_data, 32'h0000_005F);
        for (int i = 0; i < 9; i++) send(FnAccum, 32'd0, 32'd32);
        check("sat_neg", resp_data, 32'hFFFF_FF80);

        // 33 thresholds; bit i = i%2 (thr=0 -> 0, thr=1 -> 1, acc always 0)
        send(FnClear, 32'd0, 32'd0);
        for (int i = 0; i < 33; i++) send(FnThresh, (i % 2 == 1) ? 32'd1 : 32'd0, 32'd0);
        check("thresh33_act", resp_data, 32'hAAAA_AAAA);
        send(FnRead, 32'd2, 32'd0);
        check("nbits_sat32", resp_data, 32'd32);
        send(FnRead, 32'd1, 32'd0);
        check("read_last32", resp_data, 32'hAAAA_AAAA);
        send(FnRead, 32'd2, 32'd0);
        check("nbits_after_clr", resp_data, 32'd0);

        // Backpressure: hold a pending response of 3, second ACCUM(+3) waits
        send(FnClear, 32'd0, 32'd0);
        @(posedge clock);
        @(negedge clock);
        resp_ready      = 1'b0;
        req_valid       = 1'b1;
        req_function_id = FnAccum;
        req_data        = {32'd3, 32'd3};
        @(posedge clock);
        #1;
        check("bp_first", resp_data, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
            check("bp_hold_data", resp_data, 32'd3);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("bp_second_valid", {31'b0, resp_valid}, 32'd1);
        check("bp_second", resp_data, 32'd6);

        // Asynchronous reset while FULL
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("async_rst_data", resp_data, 32'd0);
        check("async_rst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        send(FnAccum, 32'd1, 32'd1);
        check("post_rst_acc", resp_data, 32'd1);
        send(FnRead, 32'd2, 32'd0);
        check("post_rst_nbits", resp_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
